// File: rtl/l2_cache_arbiter_pkg.sv
// Shared L2 front-end definitions: address width, default core count and tracker depth.
package l2_cache_arbiter_pkg;

    localparam int L2_ADDR_WIDTH   = 26;
    localparam int L2_NUM_CORES    = 4;
    localparam int L2_MISS_CREDITS = 16;

endpackage

// File: rtl/l2_cache_arbiter_checker.sv
// Protocol properties of the L2 arbiter: credit bounds and exclusive acknowledgement.
module l2_cache_arbiter_checker #(
    parameter int NUM_CORES    = 4,
    parameter int MISS_CREDITS = 16,
    parameter int CREDIT_WIDTH = $clog2(MISS_CREDITS + 1)
) (
    input logic                    clk,
    input logic                    reset_n,
    input logic [NUM_CORES-1:0]    core_req_ack,
    input logic                    fill_ack,
    input logic [CREDIT_WIDTH-1:0] credits_available
);

    // An underflow wraps to a value above capacity, so this bound catches both directions
    credits_bounded_a: assert property (@(posedge clk) disable iff (!reset_n)
        credits_available <= CREDIT_WIDTH'(MISS_CREDITS));

    ack_exclusive_a: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0({core_req_ack, fill_ack}));

    no_grant_without_credit_a: assert property (@(posedge clk) disable iff (!reset_n)
        (credits_available == '0) |-> (core_req_ack == '0));

endmodule

// File: rtl/l2_cache_arbiter_rr.sv
// Round-robin arbiter: grants the first requester after the previous winner, wrapping around.
module arbiter_rr #(
    parameter int NUM_ENTRIES = 4,
    parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_ENTRIES-1:0] request,
    input  logic                   update_lru,
    output logic [NUM_ENTRIES-1:0] grant
);

    logic [INDEX_WIDTH-1:0] pointer_r;
    logic [INDEX_WIDTH-1:0] next_pointer_s;
    logic [INDEX_WIDTH-1:0] idx_s;

    // Scan downwards so the nearest requester after the pointer is written last and wins
    always_comb begin
        grant          = '0;
        next_pointer_s = pointer_r;
        idx_s          = '0;
        for (int i = NUM_ENTRIES; i >= 1; i--) begin
            idx_s = pointer_r + INDEX_WIDTH'(i);
            if (request[idx_s]) begin
                grant          = '0;
                grant[idx_s]   = 1'b1;
                next_pointer_s = idx_s;
            end else begin
                next_pointer_s = next_pointer_s;
            end
        end
    end

    // Pointer starts at the last entry so entry 0 is first after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pointer_r <= INDEX_WIDTH'(NUM_ENTRIES - 1);
        end else if (update_lru && (|request)) begin
            pointer_r <= next_pointer_s;
        end else begin
            pointer_r <= pointer_r;
        end
    end

endmodule

// File: rtl/one_hot_to_index.sv
// Converts a one-hot (or all-zero) vector into the binary index of its set bit.
module one_hot_to_index #(
    parameter int NUM_SIGNALS = 4,
    parameter int INDEX_WIDTH = $clog2(NUM_SIGNALS)
) (
    input  logic [NUM_SIGNALS-1:0] one_hot,
    output logic [INDEX_WIDTH-1:0] index
);

    // OR together the indices of all set bits; exact for one-hot inputs, zero when idle
    always_comb begin
        index = '0;
        for (int i = 0; i < NUM_SIGNALS; i++) begin
            index = index | (INDEX_WIDTH'(i) & {INDEX_WIDTH{one_hot[i]}});
        end
    end

endmodule

// File: rtl/l2_cache_arbiter.sv
// L2 front end: picks a fill or a round-robin core request each cycle, with miss-credit admission.
module l2_cache_arbiter
    import l2_cache_arbiter_pkg::*;
#(
    parameter int NUM_CORES     = L2_NUM_CORES,
    parameter int MISS_CREDITS  = L2_MISS_CREDITS,
    parameter int CORE_ID_WIDTH = $clog2(NUM_CORES),
    parameter int CREDIT_WIDTH  = $clog2(MISS_CREDITS + 1)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_CORES-1:0]               core_req_valid,
    input  logic [NUM_CORES*L2_ADDR_WIDTH-1:0] core_req_address,
    input  logic [NUM_CORES-1:0]               core_req_store,
    output logic [NUM_CORES-1:0]               core_req_ack,
    input  logic                               fill_valid,
    input  logic [L2_ADDR_WIDTH-1:0]           fill_address,
    output logic                               fill_ack,
    input  logic                               stall_pipeline,
    input  logic                               request_resolved,
    input  logic                               miss_retired,
    output logic                               arb_valid,
    output logic [L2_ADDR_WIDTH-1:0]           arb_address,
    output logic [CORE_ID_WIDTH-1:0]           arb_core,
    output logic                               arb_is_store,
    output logic                               arb_is_l2_fill,
    output logic [CREDIT_WIDTH-1:0]            credits_available
);

    logic                     arb_valid_r;
    logic [L2_ADDR_WIDTH-1:0] arb_address_r;
    logic [CORE_ID_WIDTH-1:0] arb_core_r;
    logic                     arb_is_store_r;
    logic                     arb_is_l2_fill_r;
    logic [CREDIT_WIDTH-1:0]  credits_r;

    logic                     load_s;
    logic                     core_enable_s;
    logic                     fill_grant_s;
    logic                     core_granted_s;
    logic [NUM_CORES-1:0]     core_request_s;
    logic [NUM_CORES-1:0]     core_grant_s;
    logic [CORE_ID_WIDTH-1:0] grant_index_s;
    logic [L2_ADDR_WIDTH-1:0] sel_address_s;
    logic                     sel_store_s;
    logic [CREDIT_WIDTH-1:0]  credit_next_s;

    // Cores compete only when the stage can load, no fill is pending and a miss slot is reserved
    assign load_s         = !arb_valid_r || !stall_pipeline;
    assign fill_grant_s   = reset_n && load_s && fill_valid;
    assign core_enable_s  = reset_n && load_s && !fill_valid && (credits_r != '0);
    assign core_request_s = core_req_valid & {NUM_CORES{core_enable_s}};
    assign core_granted_s = |core_grant_s;

    arbiter_rr #(
        .NUM_ENTRIES (NUM_CORES)
    ) u_arbiter_rr (
        .clk        (clk),
        .reset_n    (reset_n),
        .request    (core_request_s),
        .update_lru (core_granted_s),
        .grant      (core_grant_s)
    );

    one_hot_to_index #(
        .NUM_SIGNALS (NUM_CORES),
        .INDEX_WIDTH (CORE_ID_WIDTH)
    ) u_grant_index (
        .one_hot (core_grant_s),
        .index   (grant_index_s)
    );

    // AND-OR mux of the granted core's address and store flag
    always_comb begin
        sel_address_s = '0;
        sel_store_s   = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            sel_address_s = sel_address_s | (core_req_address[i*L2_ADDR_WIDTH +: L2_ADDR_WIDTH]
                                             & {L2_ADDR_WIDTH{core_grant_s[i]}});
            sel_store_s   = sel_store_s | (core_req_store[i] & core_grant_s[i]);
        end
    end

    // Resolve, retire and grant all fold into a single update; modular arithmetic keeps it exact
    assign credit_next_s = credits_r + CREDIT_WIDTH'(request_resolved) + CREDIT_WIDTH'(miss_retired)
                           - CREDIT_WIDTH'(core_granted_s);

    // First pipeline stage register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arb_valid_r      <= 1'b0;
            arb_address_r    <= '0;
            arb_core_r       <= '0;
            arb_is_store_r   <= 1'b0;
            arb_is_l2_fill_r <= 1'b0;
        end else if (fill_grant_s) begin
            arb_valid_r      <= 1'b1;
            arb_address_r    <= fill_address;
            arb_core_r       <= '0;
            arb_is_store_r   <= 1'b0;
            arb_is_l2_fill_r <= 1'b1;
        end else if (core_granted_s) begin
            arb_valid_r      <= 1'b1;
            arb_address_r    <= sel_address_s;
            arb_core_r       <= grant_index_s;
            arb_is_store_r   <= sel_store_s;
            arb_is_l2_fill_r <= 1'b0;
        end else if (load_s) begin
            arb_valid_r      <= 1'b0;
        end else begin
            arb_valid_r      <= arb_valid_r;
        end
    end

    // Miss-credit counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credits_r <= CREDIT_WIDTH'(MISS_CREDITS);
        end else begin
            credits_r <= credit_next_s;
        end
    end

    assign core_req_ack      = core_grant_s;
    assign fill_ack          = fill_grant_s;
    assign arb_valid         = arb_valid_r;
    assign arb_address       = arb_address_r;
    assign arb_core          = arb_core_r;
    assign arb_is_store      = arb_is_store_r;
    assign arb_is_l2_fill    = arb_is_l2_fill_r;
    assign credits_available = credits_r;

endmodule

// File: tb/tb_l2_cache_arbiter.sv
// Scoreboard bench for l2_cache_arbiter: directed scenarios plus randomized traffic vs. a queue model.
module tb_l2_cache_arbiter;

    localparam int NC = 4;
    localparam int MC = 16;
    localparam int AW = 26;
    localparam int CW = 5;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NC-1:0]    core_req_valid;
    logic [NC*AW-1:0] core_req_address;
    logic [NC-1:0]    core_req_store;
    logic [NC-1:0]    core_req_ack;
    logic             fill_valid;
    logic [AW-1:0]    fill_address;
    logic             fill_ack;
    logic             stall_pipeline;
    logic             request_resolved;
    logic             miss_retired;
    logic             arb_valid;
    logic [AW-1:0]    arb_address;
    logic [1:0]       arb_core;
    logic             arb_is_store;
    logic             arb_is_l2_fill;
    logic [CW-1:0]    credits_available;

    always #5 clk = ~clk;

    l2_cache_arbiter #(.NUM_CORES(NC), .MISS_CREDITS(MC)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .core_req_valid    (core_req_valid),
        .core_req_address  (core_req_address),
        .core_req_store    (core_req_store),
        .core_req_ack      (core_req_ack),
        .fill_valid        (fill_valid),
        .fill_address      (fill_address),
        .fill_ack          (fill_ack),
        .stall_pipeline    (stall_pipeline),
        .request_resolved  (request_resolved),
        .miss_retired      (miss_retired),
        .arb_valid         (arb_valid),
        .arb_address       (arb_address),
        .arb_core          (arb_core),
        .arb_is_store      (arb_is_store),
        .arb_is_l2_fill    (arb_is_l2_fill),
        .credits_available (credits_available)
    );

    l2_cache_arbiter_checker #(.NUM_CORES(NC), .MISS_CREDITS(MC)) u_checker (
        .clk               (clk),
        .reset_n           (reset_n),
        .core_req_ack      (core_req_ack),
        .fill_ack          (fill_ack),
        .credits_available (credits_available)
    );

    typedef struct {
        bit            valid;
        logic [AW-1:0] addr;
        int            core;
        bit            store;
        bit            fill;
        int            credits;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: what the output stage should hold, credit count, last winning core
    bit            m_valid;
    logic [AW-1:0] m_addr;
    int            m_core;
    bit            m_store;
    bit            m_fill;
    int            m_credits;
    int            m_last;

    // Requester-side state: requests are held until the model says they were acked
    bit            p_valid [NC];
    logic [AW-1:0] p_addr  [NC];
    bit            p_store [NC];
    bit            pf_valid;
    logic [AW-1:0] pf_addr;
    bit            p_stall;
    bit            p_res;
    bit            p_ret;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid   = 1'b0;
        m_addr    = '0;
        m_core    = 0;
        m_store   = 1'b0;
        m_fill    = 1'b0;
        m_credits = MC;
        m_last    = NC - 1;
        for (int i = 0; i < NC; i++) begin
            p_valid[i] = 1'b0;
            p_addr[i]  = '0;
            p_store[i] = 1'b0;
        end
        pf_valid = 1'b0;
        pf_addr  = '0;
        p_stall  = 1'b0;
        p_res    = 1'b0;
        p_ret    = 1'b0;
    endtask

    task automatic drive_idle();
        core_req_valid   = '0;
        core_req_address = '0;
        core_req_store   = '0;
        fill_valid       = 1'b0;
        fill_address     = '0;
        stall_pipeline   = 1'b0;
        request_resolved = 1'b0;
        miss_retired     = 1'b0;
    endtask

    // One cycle: drive pending requests, predict acks and the next output-stage contents
    task automatic step();
        bit            load;
        bit            fillg;
        int            g;
        int            idx;
        logic [NC-1:0] exp_ack;
        exp_t          e;
        @(negedge clk);
        for (int i = 0; i < NC; i++) begin
            core_req_valid[i]              = p_valid[i];
            core_req_address[i*AW +: AW]   = p_addr[i];
            core_req_store[i]              = p_store[i];
        end
        fill_valid       = pf_valid;
        fill_address     = pf_addr;
        stall_pipeline   = p_stall;
        request_resolved = p_res;
        miss_retired     = p_ret;

        load  = !m_valid || !p_stall;
        fillg = load && pf_valid;
        g     = -1;
        if (load && !pf_valid && m_credits > 0) begin
            for (int k = 1; k <= NC; k++) begin
                idx = (m_last + k) % NC;
                if (p_valid[idx] && g < 0) g = idx;
            end
        end
        exp_ack = '0;
        if (g >= 0) exp_ack[g] = 1'b1;

        #1;
        check("core_req_ack", 64'(core_req_ack), 64'(exp_ack));
        check("fill_ack", 64'(fill_ack), 64'(fillg));

        if (fillg) begin
            m_valid = 1'b1; m_addr = pf_addr; m_core = 0; m_store = 1'b0; m_fill = 1'b1;
            pf_valid = 1'b0;
        end else if (g >= 0) begin
            m_valid = 1'b1; m_addr = p_addr[g]; m_core = g; m_store = p_store[g]; m_fill = 1'b0;
            m_last = g;
            p_valid[g] = 1'b0;
        end else if (load) begin
            m_valid = 1'b0;
        end
        m_credits = m_credits + int'(p_res) + int'(p_ret) - ((g >= 0) ? 1 : 0);

        e.valid = m_valid; e.addr = m_addr; e.core = m_core;
        e.store = m_store; e.fill = m_fill; e.credits = m_credits;
        sb_q.push_back(e);
    endtask

    // Monitor: after every active edge the DUT presents its stage contents for comparison
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("arb_valid", 64'(arb_valid), 64'(e.valid));
                if (e.valid) begin
                    check("arb_address", 64'(arb_address), 64'(e.addr));
                    check("arb_core", 64'(arb_core), 64'(e.core));
                    check("arb_is_store", 64'(arb_is_store), 64'(e.store));
                    check("arb_is_l2_fill", 64'(arb_is_l2_fill), 64'(e.fill));
                end
                check("credits_available", 64'(credits_available), 64'(e.credits));
            end
        end
    end

    // Asynchronous reset between edges with requests presented; outputs must clear at once
    task automatic do_reset();
        @(negedge clk);
        core_req_valid = '1;
        fill_valid     = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_arb_valid", 64'(arb_valid), 64'd0);
        check("reset_credits", 64'(credits_available), 64'(MC));
        check("reset_core_ack", 64'(core_req_ack), 64'd0);
        check("reset_fill_ack", 64'(fill_ack), 64'd0);
        sb_q.delete();
        model_reset();
        drive_idle();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic all_cores_valid();
        for (int i = 0; i < NC; i++) begin
            if (!p_valid[i]) begin
                p_valid[i] = 1'b1;
                p_addr[i]  = AW'($urandom);
                p_store[i] = 1'($urandom);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        drive_idle();
        model_reset();
        #12;
        reset_n = 1'b1;
        do_reset();

        // First request from core 0
        p_valid[0] = 1'b1; p_addr[0] = 26'h0000040; p_store[0] = 1'b0;
        step();
        step();

        // Continuous round robin from reset, then resolve five outstanding reservations
        do_reset();
        for (int n = 0; n < 5; n++) begin
            all_cores_valid();
            step();
        end
        for (int i = 0; i < NC; i++) p_valid[i] = 1'b0;
        p_res = 1'b1;
        for (int n = 0; n < 5; n++) step();
        p_res = 1'b0;

        // Fill wins over cores 1 and 2; core 1 follows
        pf_valid = 1'b1; pf_addr = 26'h3ABCDEF;
        p_valid[1] = 1'b1; p_addr[1] = 26'h0000111; p_store[1] = 1'b1;
        p_valid[2] = 1'b1; p_addr[2] = 26'h0000222; p_store[2] = 1'b0;
        step();
        step();
        step();

        // Credit exhaustion, fill still served, one retire releases core 2
        do_reset();
        while (m_credits > 0) begin
            all_cores_valid();
            step();
        end
        p_valid[2] = 1'b1; p_addr[2] = 26'h1234567;
        step();
        step();
        pf_valid = 1'b1; pf_addr = 26'h0FF00FF;
        step();
        p_ret = 1'b1;
        step();
        p_ret = 1'b0;
        step();
        step();

        // Stall holds the stage for three cycles, release loads immediately
        do_reset();
        p_valid[0] = 1'b1; p_addr[0] = 26'h2222222;
        step();
        p_valid[1] = 1'b1; p_addr[1] = 26'h1111111;
        p_valid[3] = 1'b1; p_addr[3] = 26'h3333333;
        p_stall = 1'b1;
        for (int n = 0; n < 3; n++) step();
        p_stall = 1'b0;
        step();
        step();

        // Resolve, retire and grant in one cycle at four credits
        do_reset();
        while (m_credits > 4) begin
            all_cores_valid();
            step();
        end
        for (int i = 0; i < NC; i++) p_valid[i] = 1'b0;
        p_valid[3] = 1'b1; p_addr[3] = 26'h0ABCDE0;
        p_res = 1'b1; p_ret = 1'b1;
        step();
        p_res = 1'b0; p_ret = 1'b0;
        all_cores_valid();
        step();
        do_reset();

        // Randomized traffic with occasional mid-stream resets
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) do_reset();
            for (int i = 0; i < NC; i++) begin
                if (!p_valid[i] && $urandom_range(0, 2) == 0) begin
                    p_valid[i] = 1'b1;
                    p_addr[i]  = AW'($urandom);
                    p_store[i] = 1'($urandom);
                end
            end
            if (!pf_valid && $urandom_range(0, 7) == 0) begin
                pf_valid = 1'b1;
                pf_addr  = AW'($urandom);
            end
            p_stall = ($urandom_range(0, 3) == 0);
            p_res   = (m_credits < MC) && ($urandom_range(0, 2) == 0);
            p_ret   = (m_credits + int'(p_res) < MC) && ($urandom_range(0, 2) == 0);
            step();
        end

        p_stall = 1'b0; p_res = 1'b0; p_ret = 1'b0;
        @(posedge clk);
        #2;
        check("scoreboard_drain", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_cache_arbiter.md
Name: l2_cache_arbiter

Overview:
- Front end of the L2 pipeline: selects one request per cycle from NUM_CORES core request ports and the restarted-fill port, and registers it into the first L2 pipeline stage.
- Owns admission control for the pending-miss tracker. It keeps a credit counter so that the number of possible outstanding misses never exceeds tracker capacity, which keeps the pending-miss queue from filling.
- Fills always win, because retiring fills frees entries. Cores are served round-robin.

Parameters:
- NUM_CORES, 4, number of core request ports (power of 2, >= 2).
- MISS_CREDITS, 16, pending-miss tracker capacity (must equal tracker QUEUE_SIZE).
- CORE_ID_WIDTH, $clog2(NUM_CORES), width of the core index.
- CREDIT_WIDTH, $clog2(MISS_CREDITS+1), width of the credit counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- core_req_valid  in  NUM_CORES  per-core request valid; held until acked
- core_req_address  in  NUM_CORES*26  per-core line address, core i at [i*26 +: 26]
- core_req_store  in  NUM_CORES  per-core store flag
- core_req_ack  out  NUM_CORES  one-hot grant, combinational, same cycle as load
- fill_valid  in  1  restarted fill request valid; held until acked
- fill_address  in  26  fill line address
- fill_ack  out  1  fill granted this cycle
- stall_pipeline  in  1  downstream stage cannot accept
- request_resolved  in  1  a granted core request left tag stage without allocating a miss (hit or duplicate)
- miss_retired  in  1  tracker freed an entry (fill restart cleared it)
- arb_valid  out  1  output stage holds a request
- arb_address  out  26  registered address
- arb_core  out  CORE_ID_WIDTH  registered source core (0 for fills)
- arb_is_store  out  1  registered store flag (0 for fills)
- arb_is_l2_fill  out  1  registered fill flag
- credits_available  out  CREDIT_WIDTH  current credit count

Behaviour:

Reset:
- All registered outputs clear: arb_valid, arb_address, arb_core, arb_is_store and arb_is_l2_fill go to 0.
- credits_available = MISS_CREDITS.
- Round-robin pointer = NUM_CORES-1, so core 0 is first.
- Acks are forced to 0 while reset_n is low.
- Reset mid-operation discards any held request. Requesters re-present their requests after reset.

Load enable:
- load = !arb_valid || !stall_pipeline.
- When load is 0, all registered outputs hold and all acks are 0.

Selection when load = 1:
- If fill_valid: the fill is granted. fill_ack=1, arb_is_l2_fill=1, arb_core=0, arb_is_store=0.
- Else if any core_req_valid and credits_available != 0: grant the first valid core scanning from pointer+1 with wrap-around. The granted core's ack bit is 1, arb_is_l2_fill=0, and the pointer becomes the granted index.
- Else: arb_valid <= 0. A valid core with credits==0 is stalled, not dropped.

Latency:
- A grant in cycle N makes the request visible on arb_* in cycle N+1.
- Throughput is one request per cycle when not stalled.

Credit counter:
- Next value = credits + request_resolved + miss_retired - core_grant.
- A miss that allocates converts its reservation into an occupied entry; the counter does not change at allocation.
- All three events in the same cycle combine in one update. Example: 0 + 1 + 1 - 1 = 1.
- A fill grant does not change credits.
- Assertions:
  - Never exceeds MISS_CREDITS.
  - Never underflows.
  - At most one ack is high per cycle.

Pointer:
- Changes only on a core grant. It is unaffected by fill grants and by stalls.

Decomposition:
- defines.sv gains L2_ADDR_WIDTH = 26 and L2_NUM_CORES.
- The 26-bit address width is not re-declared locally.
- Sub-module arbiter_rr (NUM_ENTRIES):
  - Inputs: request vector, update_lru enable.
  - Outputs: one-hot grant.
  - Owns the round-robin pointer.
- The existing one_hot_to_index produces arb_core from the grant.

Test Plan:
- Reset then idle: arb_valid=0, credits_available=16, all acks 0. Core 0 valid with address 0x0000040 → core_req_ack=4'b0001 that cycle; next cycle arb_valid=1, arb_address=0x0000040, arb_core=0, credits=15.
- Cores 0–3 all valid continuously, no stall → grants in order 0,1,2,3,0. Credits go 16→11 after 5 grants. Then request_resolved is pulsed 5 times → credits back to 16.
- fill_valid and cores 1 and 2 valid in the same cycle → fill_ack=1, arb_is_l2_fill=1, no core ack. The next cycle core 1 is granted.
- Credit exhaustion: 16 core grants with no resolve or retire → credits=0. Core 2 stays valid with no ack. fill_valid is still granted. One miss_retired pulse → core 2 acked the following cycle and credits return to 0.
- stall_pipeline=1 with arb_valid=1 → arb_* hold their values for 3 cycles and no acks occur. Releasing the stall → the next request loads that cycle.
- Simultaneous events: credits=4 with request_resolved, miss_retired and a core grant in the same cycle → credits=5. reset_n pulsed low mid-stream → arb_valid=0 and credits=16 asynchronously.
